// File: rtl/ltc2308_ctrl_if.sv
// LTC2308 serial pin bundle: the controller drives convst/sck/sdi, the ADC returns sdo.
`timescale 1ns/1ps
interface ltc2308_ctrl_if;
  logic convst;
  logic sck;
  logic sdi;
  logic sdo;

  modport master (output convst, output sck, output sdi, input sdo);
  modport slave  (input convst, input sck, input sdi, output sdo);
endinterface

// File: rtl/ltc2308_ctrl.sv
// LTC2308 frame sequencer: convst pulse, conversion wait, 12-bit SPI shift, fixed frame period.
// dout_cfg reports the config word that actually selected each result (one-frame ADC pipeline).
`timescale 1ns/1ps
module ltc2308_ctrl #(
  parameter int unsigned CONVST_CYC = 1,
  parameter int unsigned CONV_CYC   = 82,
  parameter int unsigned SCK_HALF   = 1,
  parameter int unsigned CYCLE_CYC  = 120
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  cont_i,
  input  logic [5:0]            cfg_i,
  output logic                  busy_o,
  output logic                  dout_valid_o,
  output logic [11:0]           dout_o,
  output logic [5:0]            dout_cfg_o,
  ltc2308_ctrl_if.master        adc_io
);

  localparam int unsigned CntW = $clog2(CYCLE_CYC + 1);
  localparam int unsigned HcW  = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  localparam logic [CntW-1:0] ConvstEnd  = CntW'(CONVST_CYC);
  localparam logic [CntW-1:0] ShiftStart = CntW'(CONVST_CYC + CONV_CYC);
  localparam logic [CntW-1:0] CycleLast  = CntW'(CYCLE_CYC - 1);
  localparam logic [HcW-1:0]  HcLast     = HcW'(SCK_HALF - 1);
  localparam logic [5:0]      PowerUpCfg = 6'b100000;

  typedef enum logic [2:0] {
    StIdle,
    StConvst,
    StConv,
    StShift,
    StGap,
    StHold
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic [HcW-1:0]  hc_q;
  logic [3:0]      nrise_q;
  logic [11:0]     shreg_q;
  logic [5:0]      sdi_sh_q;
  logic [5:0]      cur_cfg_q;
  logic [5:0]      prev_cfg_q;
  logic            hold_q;
  logic            busy_q;
  logic            dv_q;
  logic [11:0]     dout_q;
  logic [5:0]      dout_cfg_q;
  logic            convst_q;
  logic            sck_q;
  logic            sdi_q;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hc_q       <= '0;
      nrise_q    <= '0;
      shreg_q    <= '0;
      sdi_sh_q   <= '0;
      cur_cfg_q  <= '0;
      prev_cfg_q <= PowerUpCfg;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      dv_q       <= 1'b0;
      dout_q     <= '0;
      dout_cfg_q <= '0;
      convst_q   <= 1'b0;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      cnt_q <= cnt_inc;
      unique case (state_q)
        StIdle: begin
          // First cycle out of reset: hold off a full period so an aborted frame keeps tCYC.
          if (hold_q) begin
            hold_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StHold;
          end else if (start_i || cont_i) begin
            cur_cfg_q <= cfg_i;
            convst_q  <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StConvst;
          end
        end
        StHold: begin
          if (cnt_q == CycleLast) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StConvst: begin
          if (cnt_inc == ConvstEnd) begin
            convst_q <= 1'b0;
            state_q  <= StConv;
          end
        end
        StConv: begin
          if (cnt_inc == ShiftStart) begin
            sdi_q    <= cur_cfg_q[5];
            sdi_sh_q <= cur_cfg_q;
            sck_q    <= 1'b0;
            hc_q     <= '0;
            nrise_q  <= '0;
            state_q  <= StShift;
          end
        end
        StShift: begin
          if (hc_q == HcLast) begin
            hc_q <= '0;
            if (!sck_q) begin
              sck_q   <= 1'b1;
              shreg_q <= {shreg_q[10:0], adc_io.sdo};
              nrise_q <= nrise_q + 4'd1;
            end else begin
              // sdi only moves while sck goes low; bits past the config word are zero.
              sck_q    <= 1'b0;
              sdi_q    <= sdi_sh_q[4];
              sdi_sh_q <= {sdi_sh_q[4:0], 1'b0};
              if (nrise_q == 4'd12) begin
                dout_q     <= shreg_q;
                dout_cfg_q <= prev_cfg_q;
                prev_cfg_q <= cur_cfg_q;
                dv_q       <= 1'b1;
                state_q    <= StGap;
              end
            end
          end else begin
            hc_q <= hc_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == CycleLast) begin
            if (cont_i) begin
              cur_cfg_q <= cfg_i;
              convst_q  <= 1'b1;
              cnt_q     <= '0;
              state_q   <= StConvst;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign dout_valid_o  = dv_q;
  assign dout_o        = dout_q;
  assign dout_cfg_o    = dout_cfg_q;
  assign adc_io.convst = convst_q;
  assign adc_io.sck    = sck_q;
  assign adc_io.sdi    = sdi_q;

endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Bench for ltc2308_ctrl: behavioural LTC2308 model with timing checks, frame vector table,
// and directed sequences for continuous mode, busy-start rejection and mid-shift reset.
`timescale 1ns/1ps
module tb_ltc2308_ctrl;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        cont  = 1'b0;
  logic [5:0]  cfg   = 6'b0;
  logic        busy;
  logic        dv;
  logic [11:0] dout;
  logic [5:0]  dout_cfg;

  ltc2308_ctrl_if adc_if ();

  ltc2308_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cont_i       (cont),
    .cfg_i        (cfg),
    .busy_o       (busy),
    .dout_valid_o (dv),
    .dout_o       (dout),
    .dout_cfg_o   (dout_cfg),
    .adc_io       (adc_if)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- LTC2308 model ----------------
  logic [11:0] ch [8];
  logic [5:0]  m_next_cfg = 6'b100000;
  logic [5:0]  m_conv_cfg = 6'b100000;
  logic [5:0]  m_din_sh   = 6'b0;
  logic [5:0]  m_din_word = 6'b0;
  logic [11:0] m_out      = 12'h0;
  logic        m_cv_p     = 1'b0;
  logic        m_sck_p    = 1'b0;
  bit          m_have_rise = 1'b0;
  bit          m_zero_bad  = 1'b0;
  int          m_rise = 0;
  int          m_err  = 0;
  realtime     t_rise = 0.0;
  realtime     t_fall = -10000.0;
  realtime     t_sck  = -10000.0;

  assign adc_if.sdo = m_out[11];

  always @(adc_if.convst, adc_if.sck) begin
    if (adc_if.convst === 1'b1 && m_cv_p == 1'b0) begin
      if (m_have_rise && ($realtime - t_rise) < 2000.0) begin
        m_err++;
        $display("model: tCYC violation at %0t", $realtime);
      end
      m_have_rise = 1'b1;
      t_rise      = $realtime;
      m_conv_cfg  = m_next_cfg;
      m_rise      = 0;
      m_zero_bad  = 1'b0;
    end
    if (adc_if.convst === 1'b0 && m_cv_p == 1'b1) begin
      if (($realtime - t_rise) < 20.0) begin
        m_err++;
        $display("model: tWHCONV violation at %0t", $realtime);
      end
      t_fall = $realtime;
      m_out  = ch[{m_conv_cfg[3], m_conv_cfg[2], m_conv_cfg[4]}];
    end
    if (adc_if.sck === 1'b1 && m_sck_p == 1'b0) begin
      if (($realtime - t_fall) < 1600.0 || ($realtime - t_sck) < 12.0) begin
        m_err++;
        $display("model: tCONV/tWCLK violation at %0t", $realtime);
      end
      t_sck = $realtime;
      m_rise++;
      if (m_rise <= 6) begin
        m_din_sh = {m_din_sh[4:0], adc_if.sdi};
        if (m_rise == 6) begin
          m_din_word = m_din_sh;
          m_next_cfg = m_din_sh;
        end
      end else if (adc_if.sdi !== 1'b0) begin
        m_zero_bad = 1'b1;
      end
    end
    if (adc_if.sck === 1'b0 && m_sck_p == 1'b1) begin
      if (($realtime - t_sck) < 12.0) begin
        m_err++;
        $display("model: tWCLK violation at %0t", $realtime);
      end
      t_sck = $realtime;
      m_out = {m_out[10:0], 1'b0};
    end
    m_cv_p  = (adc_if.convst === 1'b1);
    m_sck_p = (adc_if.sck === 1'b1);
  end

  // ---------------- pin monitor (cycle-relative to convst rise) ----------------
  int          n_rise = 0;
  int          n_dv = 0;
  int          rise_cyc = 0;
  int          last_period = 0;
  int          first_sck = -1;
  int          hi_len = 0;
  int          frame_dv = 0;
  int          dv_rel = 0;
  logic [11:0] dv_dout = 12'h0;
  logic [5:0]  dv_cfg = 6'h0;
  logic [17:0] dv_log [$];
  logic        mon_cv_p = 1'b0;
  logic        mon_sck_p = 1'b0;

  always @(negedge clk) begin
    if (adc_if.convst === 1'b1 && !mon_cv_p) begin
      if (n_rise > 0) last_period = cyc - rise_cyc;
      rise_cyc  = cyc;
      n_rise++;
      first_sck = -1;
      hi_len    = 0;
      frame_dv  = 0;
    end
    if (adc_if.convst === 1'b1) hi_len++;
    if (adc_if.sck === 1'b1 && !mon_sck_p && first_sck < 0) first_sck = cyc - rise_cyc;
    if (dv === 1'b1) begin
      n_dv++;
      frame_dv++;
      dv_rel  = cyc - rise_cyc;
      dv_dout = dout;
      dv_cfg  = dout_cfg;
      dv_log.push_back({dout_cfg, dout});
    end
    mon_cv_p  = (adc_if.convst === 1'b1);
    mon_sck_p = (adc_if.sck === 1'b1);
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic check_ge(input string name, input int got, input int lo);
    n_total++;
    if (got >= lo) n_pass++;
    else $display("FAIL %s: got %0d, expected >= %0d", name, got, lo);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy_low(input string name, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    check(name, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_cnt(input string name, input int target);
    int k = 0;
    while ((cyc - rise_cyc) != target && k < 300) begin
      step();
      k++;
    end
    check(name, cyc - rise_cyc, target);
  endtask

  task automatic run_single(input logic [5:0] c);
    int r0;
    wait_busy_low("pre_idle", 300);
    r0    = n_rise;
    cfg   = c;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_rise", n_rise - r0, 1);
    wait_busy_low("frame_end", 300);
  endtask

  typedef struct {
    logic [5:0]  cfg;
    logic [11:0] exp_dout;
    logic [5:0]  exp_cfg;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int r0;
    int dv0;

    // Result of frame N was selected by the config word of frame N-1.
    vecs[0] = '{cfg: 6'b100000, exp_dout: 12'hA5C, exp_cfg: 6'b100000};
    vecs[1] = '{cfg: 6'b100100, exp_dout: 12'hA5C, exp_cfg: 6'b100000};
    vecs[2] = '{cfg: 6'b110110, exp_dout: 12'h123, exp_cfg: 6'b100100};
    vecs[3] = '{cfg: 6'b111100, exp_dout: 12'h3C7, exp_cfg: 6'b110110};
    vecs[4] = '{cfg: 6'b101000, exp_dout: 12'hFFF, exp_cfg: 6'b111100};
    vecs[5] = '{cfg: 6'b100000, exp_dout: 12'h001, exp_cfg: 6'b101000};
    for (int i = 0; i < 8; i++) ch[i] = 12'h555;
    ch[0] = 12'hA5C;
    ch[2] = 12'h123;
    ch[3] = 12'h3C7;
    ch[4] = 12'h001;
    ch[7] = 12'hFFF;

    // Reset values and post-reset holdoff
    repeat (3) step();
    check("rst_convst", {31'b0, adc_if.convst}, 0);
    check("rst_sck", {31'b0, adc_if.sck}, 0);
    check("rst_sdi", {31'b0, adc_if.sdi}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_dv", {31'b0, dv}, 0);
    check("rst_dout", {20'b0, dout}, 0);
    check("rst_dout_cfg", {26'b0, dout_cfg}, 0);
    rst = 1'b0;
    d   = cyc;
    step();
    check("holdoff_busy", {31'b0, busy}, 1);
    repeat (60) step();
    check("holdoff_busy_mid", {31'b0, busy}, 1);
    wait_busy_low("holdoff_end", 200);
    check("holdoff_len", cyc - d - 1, 120);
    check("holdoff_no_frame", n_rise, 0);

    // Single-start frame table
    for (int i = 0; i < 6; i++) begin
      run_single(vecs[i].cfg);
      check($sformatf("v%0d_dv_count", i), frame_dv, 1);
      check($sformatf("v%0d_dout", i), {20'b0, dv_dout}, {20'b0, vecs[i].exp_dout});
      check($sformatf("v%0d_dout_cfg", i), {26'b0, dv_cfg}, {26'b0, vecs[i].exp_cfg});
      check($sformatf("v%0d_dv_cnt", i), dv_rel, 107);
      check($sformatf("v%0d_first_sck", i), first_sck, 84);
      check($sformatf("v%0d_convst_hi", i), hi_len, 1);
      check($sformatf("v%0d_din_word", i), {26'b0, m_din_word}, {26'b0, vecs[i].cfg});
      check($sformatf("v%0d_sdi_tail_zero", i), {31'b0, m_zero_bad}, 0);
    end

    // Continuous mode, with cfg wiggled mid-frame
    wait_busy_low("cont_pre", 300);
    r0   = n_rise;
    dv0  = n_dv;
    cfg  = 6'b100100;
    cont = 1'b1;
    step();
    check("cont_rise1", n_rise - r0, 1);
    repeat (10) step();
    cfg = 6'b111111;
    wait_cnt("cont_cnt60", 60);
    cfg = 6'b100100;
    begin
      int k = 0;
      while (n_rise - r0 < 2 && k < 300) begin
        step();
        k++;
      end
    end
    cont = 1'b0;
    check("cont_rise2", n_rise - r0, 2);
    check("cont_period", last_period, 120);
    wait_busy_low("cont_end", 300);
    check("cont_dv_count", n_dv - dv0, 2);
    check("cont_f1", {14'b0, dv_log[dv_log.size()-2]}, {14'b0, 6'b100000, 12'hA5C});
    check("cont_f2", {14'b0, dv_log[dv_log.size()-1]}, {14'b0, 6'b100100, 12'h123});
    check("cont_din_word", {26'b0, m_din_word}, {26'b0, 6'b100100});

    // start pulsed at cnt 50 of an active frame is ignored
    wait_busy_low("busy_start_pre", 300);
    cfg   = 6'b100000;
    start = 1'b1;
    step();
    start = 1'b0;
    r0  = n_rise;
    dv0 = n_dv;
    wait_cnt("busy_start_cnt50", 50);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_busy_low("busy_start_end", 300);
    repeat (150) step();
    check("busy_start_rises", n_rise - r0, 0);
    check("busy_start_dv", n_dv - dv0, 1);
    check("busy_start_dout", {20'b0, dv_dout}, 32'h123);
    check("busy_start_cfg", {26'b0, dv_cfg}, 32'b100100);

    // Reset mid-SHIFT with start held high
    wait_busy_low("rst_mid_pre", 300);
    cfg   = 6'b100000;
    start = 1'b1;
    step();
    dv0 = n_dv;
    wait_cnt("rst_mid_cnt95", 95);
    rst = 1'b1;
    repeat (2) step();
    check("rst_mid_convst", {31'b0, adc_if.convst}, 0);
    check("rst_mid_sck", {31'b0, adc_if.sck}, 0);
    check("rst_mid_sdi", {31'b0, adc_if.sdi}, 0);
    check("rst_mid_busy", {31'b0, busy}, 0);
    check("rst_mid_dout", {20'b0, dout}, 0);
    check("rst_mid_dout_cfg", {26'b0, dout_cfg}, 0);
    rst = 1'b0;
    d   = cyc;
    r0  = n_rise;
    begin
      int k = 0;
      while (n_rise == r0 && k < 300) begin
        step();
        k++;
      end
    end
    start = 1'b0;
    check("rst_mid_restart", n_rise - r0, 1);
    check_ge("rst_mid_holdoff", rise_cyc - d, 120);
    check("rst_mid_no_dv", n_dv - dv0, 0);
    wait_busy_low("rst_mid_end", 300);
    check("rst_mid_next_dv", frame_dv, 1);
    check("rst_mid_next_dout", {20'b0, dv_dout}, 32'hA5C);
    check("rst_mid_next_cfg", {26'b0, dv_cfg}, 32'b100000);

    check("model_timing_errors", m_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
